// File: rtl/byte_ser_pkg.sv
// Shared definitions for the byte serializer controller.
//   state_e  : controller states (IDLE=0, SEND=1)
//   BYTE_W   : bits per byte
//   NBYTES   : bytes per input block
//   CNT_W    : width of the byte counter / byte select
//   sel_of() : maps a byte counter to the byte select for a given order
package byte_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NBYTES = 16;
  localparam int unsigned CNT_W  = 4;

  function automatic logic [CNT_W-1:0] sel_of(input logic [CNT_W-1:0] cnt,
                                              input logic             msb_first);
    return msb_first ? (CNT_W'(NBYTES - 1) - cnt) : cnt;
  endfunction

endpackage

// File: rtl/mux_16to1.sv
// 16-to-1 byte multiplexer.
//   data_i : 16 packed bytes, byte k at bits [8k+7:8k]
//   sel_i  : byte index
//   data_o : selected byte
module mux_16to1
  import byte_ser_pkg::*;
(
  input  logic [NBYTES*BYTE_W-1:0] data_i,
  input  logic [CNT_W-1:0]         sel_i,
  output logic [BYTE_W-1:0]        data_o
);

  always_comb begin
    data_o = data_i[sel_i*BYTE_W +: BYTE_W];
  end

endmodule

// File: rtl/byte_serializer_ctrl.sv
// Serializes a 16-byte block into a valid/ready byte stream.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : block handshake; in_data (16 bytes), in_len (bytes-1)
//   out_valid/out_ready  : byte handshake; out_data, out_last (final byte)
//   sel                  : byte select driven to the mux
//   busy                 : high while sending a block
// MSB_FIRST=0 emits byte 0 first, MSB_FIRST=1 emits byte 15 first.
module byte_serializer_ctrl
  import byte_ser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NBYTES*BYTE_W-1:0] in_data,
  input  logic [CNT_W-1:0]         in_len,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W-1:0]        out_data,
  output logic                     out_last,
  output logic [CNT_W-1:0]         sel,
  output logic                     busy
);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          cnt_inc;
  logic [CNT_W-1:0]          len_q, len_d;
  logic [CNT_W-1:0]          sel_q, sel_d;
  logic [NBYTES*BYTE_W-1:0]  data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      sel_q   <= sel_of('0, MSB_FIRST);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  // sel is registered rather than derived from cnt so that it keeps the
  // last emitted byte index while IDLE, even though cnt returns to 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    data_d    = data_q;
    sel_d     = sel_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          len_d   = in_len;
          cnt_d   = '0;
          sel_d   = sel_of('0, MSB_FIRST);
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = (cnt_q == len_q);
        if (out_ready) begin
          if (out_last) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
            sel_d = sel_of(cnt_inc, MSB_FIRST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel = sel_q;

  mux_16to1 u_mux (
    .data_i (data_q),
    .sel_i  (sel_q),
    .data_o (out_data)
  );

endmodule

// File: tb/tb_byte_serializer_ctrl.sv
module tb_byte_serializer_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic [3:0]   in_len = '0;
  logic         out_ready = 1'b0;

  logic       in_ready0, out_valid0, out_last0, busy0;
  logic [7:0] out_data0;
  logic [3:0] sel0;
  logic       in_ready1, out_valid1, out_last1, busy1;
  logic [7:0] out_data1;
  logic [3:0] sel1;

  int checks = 0;
  int errors = 0;

  // Reference model: per-order queues of the bytes (and their indices)
  // still to be emitted for the current block; empty queue means idle.
  logic [7:0] exp_b0[$], exp_b1[$];
  logic [3:0] exp_s0[$], exp_s1[$];
  logic [3:0] last_sel0 = 4'd0, last_sel1 = 4'd15;

  always #5 clk = ~clk;

  byte_serializer_ctrl #(.MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_len(in_len), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_last(out_last0),
    .sel(sel0), .busy(busy0)
  );

  byte_serializer_ctrl #(.MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_len(in_len), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .out_last(out_last1),
    .sel(sel1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    logic act;
    act = (exp_b0.size() != 0);
    chk("lsb.in_ready",  32'(in_ready0),  32'(!act));
    chk("lsb.out_valid", 32'(out_valid0), 32'(act));
    chk("lsb.busy",      32'(busy0),      32'(act));
    chk("lsb.out_last",  32'(out_last0),  32'(exp_b0.size() == 1));
    chk("lsb.sel",       32'(sel0),       32'(act ? exp_s0[0] : last_sel0));
    if (act) chk("lsb.out_data", 32'(out_data0), 32'(exp_b0[0]));
    act = (exp_b1.size() != 0);
    chk("msb.in_ready",  32'(in_ready1),  32'(!act));
    chk("msb.out_valid", 32'(out_valid1), 32'(act));
    chk("msb.busy",      32'(busy1),      32'(act));
    chk("msb.out_last",  32'(out_last1),  32'(exp_b1.size() == 1));
    chk("msb.sel",       32'(sel1),       32'(act ? exp_s1[0] : last_sel1));
    if (act) chk("msb.out_data", 32'(out_data1), 32'(exp_b1[0]));
  endtask

  // One clock: check outputs, drive inputs, advance the model to what the
  // next rising edge should produce.
  task automatic step(input logic iv, input logic [127:0] d, input logic [3:0] l,
                      input logic ordy);
    @(negedge clk);
    check_all();
    in_valid  = iv;
    in_data   = d;
    in_len    = l;
    out_ready = ordy;
    if (exp_b0.size() != 0) begin
      if (ordy) begin
        last_sel0 = exp_s0.pop_front();
        last_sel1 = exp_s1.pop_front();
        void'(exp_b0.pop_front());
        void'(exp_b1.pop_front());
      end
    end else if (iv) begin
      for (int unsigned i = 0; i <= 32'(l); i++) begin
        exp_b0.push_back(d[i*8 +: 8]);
        exp_s0.push_back(4'(i));
        exp_b1.push_back(d[(15-i)*8 +: 8]);
        exp_s1.push_back(4'(15 - i));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_all();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.in_ready0",  32'(in_ready0),  32'd1);
    chk("rst.out_valid0", 32'(out_valid0), 32'd0);
    chk("rst.out_last0",  32'(out_last0),  32'd0);
    chk("rst.busy0",      32'(busy0),      32'd0);
    chk("rst.sel0",       32'(sel0),       32'd0);
    chk("rst.in_ready1",  32'(in_ready1),  32'd1);
    chk("rst.out_valid1", 32'(out_valid1), 32'd0);
    chk("rst.out_last1",  32'(out_last1),  32'd0);
    chk("rst.sel1",       32'(sel1),       32'd15);
    exp_b0.delete(); exp_b1.delete(); exp_s0.delete(); exp_s1.delete();
    last_sel0 = 4'd0;
    last_sel1 = 4'd15;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [127:0] blk;
    logic [127:0] alt;
    for (int unsigned i = 0; i < 16; i++) blk[i*8 +: 8] = 8'(i);
    alt = ~blk;

    do_reset();

    // Full 16-byte block, streaming.
    step(1'b1, blk, 4'd15, 1'b1);
    for (int i = 0; i < 18; i++) step(1'b0, '0, 4'd0, 1'b1);

    // Single byte.
    step(1'b1, blk, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 4'd0, 1'b1);

    // Back-pressure on a 4-byte block.
    step(1'b1, blk, 4'd3, 1'b0);
    step(1'b0, '0, 4'd0, 1'b1);
    step(1'b0, '0, 4'd0, 1'b0);
    step(1'b0, '0, 4'd0, 1'b0);
    step(1'b0, '0, 4'd0, 1'b1);
    step(1'b0, '0, 4'd0, 1'b0);
    step(1'b0, '0, 4'd0, 1'b1);
    step(1'b0, '0, 4'd0, 1'b1);
    step(1'b0, '0, 4'd0, 1'b1);
    chk("stall.drained", 32'(exp_b0.size()), 32'd0);

    // Reset in the middle of a block, then a 2-byte block.
    step(1'b1, blk, 4'd15, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 4'd0, 1'b1);
    do_reset();
    step(1'b1, blk, 4'd1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 4'd0, 1'b1);

    // in_valid held high across a block with changing data.
    step(1'b1, blk, 4'd2, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, alt, 4'd1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 4'd0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)),
           {$urandom, $urandom, $urandom, $urandom},
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 40; i++) step(1'b0, '0, 4'd0, 1'b1);
    chk("final.idle", 32'(exp_b0.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
